// File: rtl/mio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mio_pkg
// Brief   : Shared types and constants for the MIO bus slave: FSM state
//           encoding, address map, TCTRL bit positions and a byte-merge helper.
// Revision: 1.0 - initial release
// ============================================================================
package mio_pkg;

    // Bus slave FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Address map: RAM lives below c_ram_limit (Addr[31:12] == 0)
    localparam logic [31:0] c_ram_limit   = 32'h0000_1000;
    localparam logic [31:0] c_tcount_addr = 32'hFFFF_0000;
    localparam logic [31:0] c_tcmp_addr   = 32'hFFFF_0004;
    localparam logic [31:0] c_tctrl_addr  = 32'hFFFF_0008;

    // TCTRL bit positions
    localparam int c_tctrl_en_bit   = 0;
    localparam int c_tctrl_pend_bit = 1;

    // Replace only the byte lanes of old_word selected by be
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mio_bus_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : mio_bus_slave_if
// Brief   : CPU <-> MIO bus signal bundle with master (CPU) and slave views.
// Revision: 1.0 - initial release
// ============================================================================
interface mio_bus_slave_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_w;
    logic [3:0]  BE;
    logic [31:0] Data_r;
    logic        MIO_ready;
    logic        INT;

    modport master (
        output CPU_MIO, mem_w, Addr_in, Data_w, BE,
        input  Data_r, MIO_ready, INT
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_in, Data_w, BE,
        output Data_r, MIO_ready, INT
    );
endinterface
`default_nettype wire

// File: rtl/mio_timer.sv
`default_nettype none
// ============================================================================
// Module  : mio_timer
// Brief   : Free-running compare timer: TCOUNT, TCMP and TCTRL registers with
//           a level interrupt that mirrors TCTRL.pending.
// Revision: 1.0 - initial release
// ============================================================================
module mio_timer
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wr_cmp,
    input  logic        i_wr_ctrl,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic [31:0] o_tcount,
    output logic [31:0] o_tcmp,
    output logic [31:0] o_tctrl,
    output logic        o_int
);

    logic [31:0] r_tcount;
    logic [31:0] r_tcmp;
    logic        r_en;
    logic        r_pend;
    logic        w_match;
    logic        w_ctrl_lane0;

    assign w_match      = r_en && (r_tcount == r_tcmp);
    // Both TCTRL bits live in byte lane 0
    assign w_ctrl_lane0 = i_wr_ctrl && i_be[0];

    // Counter, compare register and control bits; a compare match beats a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcount <= '0;
            r_tcmp   <= '0;
            r_en     <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            if (r_en) r_tcount <= r_tcount + 32'd1;
            if (i_wr_cmp) r_tcmp <= be_merge(r_tcmp, i_wdata, i_be);
            if (w_ctrl_lane0) r_en <= i_wdata[c_tctrl_en_bit];
            if (w_match)
                r_pend <= 1'b1;
            else if (w_ctrl_lane0 && i_wdata[c_tctrl_pend_bit])
                r_pend <= 1'b0;
        end
    end

    // Assemble the TCTRL read view from the individual bits
    always_comb begin
        o_tctrl                   = '0;
        o_tctrl[c_tctrl_en_bit]   = r_en;
        o_tctrl[c_tctrl_pend_bit] = r_pend;
    end

    assign o_tcount = r_tcount;
    assign o_tcmp   = r_tcmp;
    assign o_int    = r_pend;

endmodule
`default_nettype wire

// File: rtl/mio_bus_slave.sv
`default_nettype none
// ============================================================================
// Module  : mio_bus_slave
// Brief   : CPU memory/IO slave with programmable wait states, word RAM with
//           byte enables and a memory-mapped compare timer.
// Revision: 1.0 - initial release
// ============================================================================
module mio_bus_slave
    import mio_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_WORDS   = 1024
) (
    input  logic           clk,
    input  logic           reset,
    mio_bus_slave_if.slave bus
);

    localparam int         c_aw        = $clog2(MEM_WORDS);
    localparam logic [3:0] c_wait_init = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_ready;
    logic [31:0] r_data_r;
    logic [31:0] r_mem [MEM_WORDS];

    logic [c_aw-1:0] w_idx;
    logic            w_ram_hit;
    logic            w_commit;
    logic            w_ram_we;
    logic [31:0]     w_rdata;
    logic [31:0]     w_tcount;
    logic [31:0]     w_tcmp;
    logic [31:0]     w_tctrl;
    logic            w_int;

    // Decode of the latched request; the access takes effect on the RESP edge
    assign w_idx     = r_addr[c_aw+1:2];
    assign w_ram_hit = (r_addr < c_ram_limit);
    assign w_commit  = (r_state == ST_RESP) && r_we;
    assign w_ram_we  = w_commit && w_ram_hit;

    mio_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_wr_cmp (w_commit && (r_addr == c_tcmp_addr)),
        .i_wr_ctrl(w_commit && (r_addr == c_tctrl_addr)),
        .i_wdata  (r_wdata),
        .i_be     (r_be),
        .o_tcount (w_tcount),
        .o_tcmp   (w_tcmp),
        .o_tctrl  (w_tctrl),
        .o_int    (w_int)
    );

    // Read data mux; anything outside the map reads as zero
    always_comb begin
        w_rdata = '0;
        if (w_ram_hit)                    w_rdata = r_mem[w_idx];
        else if (r_addr == c_tcount_addr) w_rdata = w_tcount;
        else if (r_addr == c_tcmp_addr)   w_rdata = w_tcmp;
        else if (r_addr == c_tctrl_addr)  w_rdata = w_tctrl;
    end

    // Request FSM: latch in IDLE, count wait states, respond with a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_ready    <= 1'b0;
            r_data_r   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.CPU_MIO) begin
                        r_addr     <= bus.Addr_in;
                        r_wdata    <= bus.Data_w;
                        r_be       <= bus.BE;
                        r_we       <= bus.mem_w;
                        r_wait_cnt <= c_wait_init;
                        r_state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) r_state    <= ST_RESP;
                    else                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                ST_RESP: begin
                    r_ready  <= 1'b1;
                    r_data_r <= w_rdata;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.Data_r    = r_data_r;
    assign bus.MIO_ready = r_ready;
    assign bus.INT       = w_int;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_mio_bus_slave
// Brief   : Self-checking bench for mio_bus_slave (WAIT_CYCLES=2 and =0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mio_bus_slave;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] model_ram [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mio_bus_slave_if b0 ();
    mio_bus_slave_if b1 ();

    mio_bus_slave #(.WAIT_CYCLES(2), .MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .bus(b0)
    );

    mio_bus_slave #(.WAIT_CYCLES(0), .MEM_WORDS(1024)) dut_w0 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference byte-enable rule: selected lanes take new data, others keep old
    function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One access on the WAIT_CYCLES=2 DUT; reports the commit edge number
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int commit);
        int t;
        bit got;
        rdata  = 'x;
        commit = -1;
        @(negedge clk);
        b0.CPU_MIO = 1'b1; b0.mem_w = we; b0.Addr_in = addr; b0.Data_w = wdata; b0.BE = be;
        @(posedge clk); #1;
        t = cyc;
        b0.CPU_MIO = 1'b0;
        b0.mem_w = 1'($urandom); b0.Addr_in = $urandom; b0.Data_w = $urandom; b0.BE = 4'($urandom);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b0.MIO_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            check("ready_latency", 32'(cyc - t), 32'd3);
            rdata  = b0.Data_r;
            commit = cyc;
            @(posedge clk); #1;
            check("ready_one_cycle", {31'd0, b0.MIO_ready}, 32'd0);
        end
    endtask

    task automatic ram_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] rd;
        int c;
        access(1'b1, addr, wdata, be, rd, c);
        if (addr < 32'h1000 && addr[11:2] < 10'd16)
            model_ram[addr[5:2]] = model_merge(model_ram[addr[5:2]], wdata, be);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int c;
        access(1'b0, addr, 32'd0, 4'($urandom), rd, c);
        check(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          e, c, a;
        bit          got;

        b0.CPU_MIO = 0; b0.mem_w = 0; b0.Addr_in = 0; b0.Data_w = 0; b0.BE = 0;
        b1.CPU_MIO = 0; b1.mem_w = 0; b1.Addr_in = 0; b1.Data_w = 0; b1.BE = 0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, b0.MIO_ready}, 32'd0);
        check("rst_data_r", b0.Data_r, 32'd0);
        check("rst_int", {31'd0, b0.INT}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        read_check("rst_tcount", 32'hFFFF_0000, 32'd0);
        read_check("rst_tctrl", 32'hFFFF_0008, 32'd0);

        // Known contents for the first 16 RAM words
        for (int i = 0; i < 16; i++) ram_write(32'(i * 4), $urandom, 4'hF);

        // Full write then read back; byte-lane write; BE=0000 write
        ram_write(32'h10, 32'h1234_5678, 4'hF);
        read_check("word_write", 32'h10, 32'h1234_5678);
        ram_write(32'h10, 32'h0000_00AB, 4'h1);
        read_check("be_0001", 32'h10, 32'h1234_56AB);
        ram_write(32'h10, 32'hDEAD_BEEF, 4'h0);
        read_check("be_0000", 32'h10, 32'h1234_56AB);
        read_check("addr_lsb_ignored", 32'h13, 32'h1234_56AB);

        // Randomized RAM traffic against the model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] addr;
            addr = {26'd0, 4'($urandom), 2'($urandom)};
            if ($urandom_range(1, 0) == 1) ram_write(addr, $urandom, 4'($urandom));
            else read_check("rand_read", addr, model_ram[addr[5:2]]);
        end

        // Unmapped reads and writes
        read_check("unmapped_8000", 32'h8000_0000, 32'd0);
        read_check("unmapped_fffc", 32'hFFFF_000C, 32'd0);
        ram_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF);
        ram_write(32'h0000_1010, 32'h5555_AAAA, 4'hF);
        for (int i = 0; i < 16; i++) read_check("ram_untouched", 32'(i * 4), model_ram[i]);

        // Reset during WAIT aborts the write to 0x20
        @(negedge clk);
        b0.CPU_MIO = 1'b1; b0.mem_w = 1'b1; b0.Addr_in = 32'h20; b0.Data_w = ~model_ram[8]; b0.BE = 4'hF;
        @(posedge clk); #1;
        b0.CPU_MIO = 1'b0;
        reset = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (b0.MIO_ready) got = 1'b1;
        end
        check("abort_no_ready", {31'd0, got}, 32'd0);
        check("abort_data_r", b0.Data_r, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        read_check("abort_no_write", 32'h20, model_ram[8]);

        // Timer: TCMP=5, enable, INT rises one edge after TCOUNT reaches 5
        access(1'b1, 32'hFFFF_0004, 32'd5, 4'hF, rd, c);
        access(1'b1, 32'hFFFF_0008, 32'd1, 4'hF, rd, e);
        while (cyc < e + 5) begin @(posedge clk); #1; end
        check("int_before_match", {31'd0, b0.INT}, 32'd0);
        @(posedge clk); #1;
        check("int_after_match", {31'd0, b0.INT}, 32'd1);
        access(1'b0, 32'hFFFF_0008, 32'd0, 4'hF, rd, c);
        check("tctrl_pending", rd, 32'd3);
        access(1'b0, 32'hFFFF_0004, 32'd0, 4'hF, rd, c);
        check("tcmp_read", rd, 32'd5);
        access(1'b1, 32'hFFFF_0008, 32'd3, 4'hF, rd, c);
        check("int_cleared", {31'd0, b0.INT}, 32'd0);
        access(1'b0, 32'hFFFF_0000, 32'd0, 4'hF, rd, c);
        check("tcount_running", rd, 32'(c - 1 - e));
        access(1'b1, 32'hFFFF_0000, 32'd0, 4'hF, rd, c);
        access(1'b0, 32'hFFFF_0000, 32'd0, 4'hF, rd, c);
        check("tcount_readonly", rd, 32'(c - 1 - e));

        // WAIT_CYCLES=0, back-to-back requests: ready on every second edge
        @(negedge clk);
        b1.CPU_MIO = 1'b1; b1.mem_w = 1'b0; b1.Addr_in = 32'hFFFF_0000; b1.BE = 4'hF;
        @(posedge clk); #1;
        a = cyc;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("w0_ready_pattern", {31'd0, b1.MIO_ready}, 32'(k % 2));
            if (b1.MIO_ready) check("w0_data", b1.Data_r, 32'd0);
        end
        b1.CPU_MIO = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mio_bus_slave.md
MIO_BUS_SLAVE -- requirements
Module: mio_bus_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted before each response (range 0..15).
REQ-002 Parameter MEM_WORDS, default 1024, SHALL set the RAM depth in 32-bit words (power of two).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 CPU_MIO  in  1  SHALL be the request strobe from the CPU (1 = access requested).
REQ-006 mem_w  in  1  SHALL be the write flag (1 = write, 0 = read).
REQ-007 Addr_in  in  32  SHALL be the byte address of the access.
REQ-008 Data_w  in  32  SHALL be the write data.
REQ-009 BE  in  4  SHALL be the byte enables; BE[i] selects Data_w[8i+7:8i].
REQ-010 Data_r  out  32  SHALL be the read data; it is valid only while MIO_ready=1.
REQ-011 MIO_ready  out  1  SHALL be the completion pulse to the CPU.
REQ-012 INT  out  1  SHALL be the timer interrupt request (level).

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
- IDLE with CPU_MIO=1 -> latch Addr_in, Data_w, BE and mem_w, then go to WAIT (or to RESP if WAIT_CYCLES=0).
- WAIT -> RESP after WAIT_CYCLES cycles.
- RESP -> IDLE unconditionally.
REQ-014 A request accepted at edge t SHALL produce MIO_ready=1 for exactly one cycle, after edge t+1+WAIT_CYCLES.
REQ-015 Inputs SHALL be ignored outside IDLE; a new request MAY be accepted in the cycle right after RESP.
REQ-016 The address map SHALL be:
- RAM: Addr[31:12]=0; word index = Addr[log2(MEM_WORDS)+1:2]; Addr[1:0] ignored.
- TCOUNT at 0xFFFF0000 (read-only).
- TCMP at 0xFFFF0004 (read/write).
- TCTRL at 0xFFFF0008 (bit0 = enable, bit1 = pending).
REQ-017 RAM writes SHALL be committed on the RESP edge and SHALL update only the bytes whose BE bit is set; BE=0000 SHALL leave memory unchanged.
REQ-018 Reads SHALL return the full 32-bit word regardless of BE; byte selection and extension are the CPU's job.
REQ-019 Unmapped addresses SHALL read as 0, writes to them SHALL be dropped, and MIO_ready SHALL still pulse.
REQ-020 When TCTRL.enable=1, TCOUNT SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-021 When TCOUNT==TCMP and enable=1, TCTRL.pending SHALL be set; INT SHALL equal pending.
REQ-022 Writing TCTRL bit1=1 SHALL clear pending; if a clear coincides with a compare match, the set SHALL win.
REQ-023 Writing TCTRL bit0 SHALL enable or disable counting; writing TCMP SHALL NOT reset TCOUNT.
REQ-024 Register writes SHALL honour BE in the same way as RAM writes.

Reset
REQ-025 Reset SHALL force state=IDLE, MIO_ready=0, Data_r=0, INT=0 and TCOUNT=TCMP=TCTRL=0.
REQ-026 Reset during WAIT or RESP SHALL abort the access: no write is committed and no MIO_ready pulse is produced.
REQ-027 RAM contents SHALL NOT be reset.

Structure
REQ-028 Package mio_pkg SHALL hold the FSM state encoding, the address-map constants (RAM limit, TCOUNT/TCMP/TCTRL addresses) and the TCTRL bit positions.
REQ-029 The timer SHALL be a sub-module named mio_timer (TCOUNT/TCMP/TCTRL registers, INT generation); RAM and FSM SHALL stay in mio_bus_slave.

Verification
REQ-030 Write 0x12345678 to 0x10 with BE=1111, then read 0x10 -> Data_r=0x12345678, with each MIO_ready exactly 3 cycles after acceptance (WAIT_CYCLES=2).
REQ-031 Write 0x000000AB to 0x10 with BE=0001 over 0x12345678 -> read returns 0x123456AB; a write with BE=0000 leaves it unchanged.
REQ-032 Write TCMP=5, then TCTRL=1 -> INT rises when TCOUNT=5; writing TCTRL=0x3 -> INT drops and counting continues.
REQ-033 Read of 0x8000_0000 -> Data_r=0 with MIO_ready pulsed; a write there changes no RAM word.
REQ-034 Assert reset during WAIT of a write to 0x20 -> no MIO_ready pulse; a subsequent read of 0x20 returns the prior value.
REQ-035 With WAIT_CYCLES=0 and back-to-back requests -> MIO_ready pulses on every second cycle.
